lap_tracker: RTL and testbench

// Consumes one car's pos_x/pos_y from its PhysicsEngine instance and tracks race progress.

---
 rtl/lap_tracker.sv | 143 ++++++++++++++
 tb/tb_lap_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lap_tracker.sv
// lap_tracker: per-car race progress. Enforces the ordered 4-gate circuit,
// counts laps, times the current lap and the whole race in 60 Hz game ticks,
// and raises a sticky finished flag for the game FSM.
module lap_tracker #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         NUM_LAPS = 3,
  parameter logic [9:0] CP_HALF  = 10'd12,
  parameter logic [9:0] CP0_X    = 10'd0,
  parameter logic [9:0] CP0_Y    = 10'd120,
  parameter logic [9:0] CP1_X    = 10'd160,
  parameter logic [9:0] CP1_Y    = 10'd20,
  parameter logic [9:0] CP2_X    = 10'd300,
  parameter logic [9:0] CP2_Y    = 10'd120,
  parameter logic [9:0] CP3_X    = 10'd160,
  parameter logic [9:0] CP3_Y    = 10'd220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [1:0]  next_cp,
  output logic [2:0]  lap_cnt,
  output logic        lap_pulse,
  output logic        finished,
  output logic [15:0] lap_time,
  output logic [15:0] last_lap,
  output logic [15:0] best_lap,
  output logic [15:0] race_time
);

  // Tick divider shared with PhysicsEngine: counts 0..CLK_FREQ/60.
  localparam int TICK_MAX = CLK_FREQ / 60;
  localparam int TW       = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);

  localparam logic [2:0] GS_MENU   = 3'd0;
  localparam logic [2:0] GS_RACING = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RACING, S_DONE} fsm_t;

  fsm_t          fsm, fsm_next;
  logic [TW-1:0] tick_cnt;
  logic          game_tick;
  logic          active;
  logic          new_game;
  logic [9:0]    cx, cy;
  logic          hit;
  logic          lap_done;
  logic [2:0]    lap_cnt_inc;
  logic          final_lap;

  // |a-b| through an 11-bit signed difference, so it never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign game_tick   = (tick_cnt == '0);
  assign active      = (fsm == S_RACING) && (state == GS_RACING);
  assign new_game    = (state == GS_MENU);
  assign hit         = active
                       && (abs_diff(pos_x, cx) <= {1'b0, CP_HALF})
                       && (abs_diff(pos_y, cy) <= {1'b0, CP_HALF});
  assign lap_done    = hit && (next_cp == 2'd0);
  assign lap_cnt_inc = lap_cnt + 3'd1;
  assign final_lap   = lap_done && (lap_cnt_inc == 3'(NUM_LAPS));

  // Select the centre of the only gate that is currently tested.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cx = CP0_X;
    cy = CP0_Y;
    case (next_cp)
      2'd1:    begin cx = CP1_X; cy = CP1_Y; end
      2'd2:    begin cx = CP2_X; cy = CP2_Y; end
      2'd3:    begin cx = CP3_X; cy = CP3_Y; end
      default: begin cx = CP0_X; cy = CP0_Y; end
    endcase
  end

  // Free-running game tick divider; only rst resynchronises it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst)                          tick_cnt <= '0;
    else if (tick_cnt == TW'(TICK_MAX)) tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + TW'(1);
  end

  // Race FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_next;
  end

  // Race FSM next state: pause drops to IDLE, final lap latches DONE, menu restarts.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_IDLE:   if (state == GS_RACING) fsm_next = S_RACING;
      S_RACING: begin
        if (state != GS_RACING) fsm_next = S_IDLE;
        else if (final_lap)     fsm_next = S_DONE;
      end
      S_DONE:   fsm_next = S_DONE;
      default:  fsm_next = S_IDLE;
    endcase
    if (new_game) fsm_next = S_IDLE;
  end

  // Progress, lap statistics and timers; frozen whenever not actively racing.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      next_cp   <= 2'd1;
      lap_cnt   <= 3'd0;
      lap_pulse <= 1'b0;
      finished  <= 1'b0;
      lap_time  <= 16'd0;
      last_lap  <= 16'd0;
      best_lap  <= 16'hFFFF;
      race_time <= 16'd0;
    end else begin
      lap_pulse <= lap_done;

      if (lap_done) begin
        lap_cnt  <= lap_cnt_inc;
        last_lap <= lap_time;
        if (lap_time < best_lap) best_lap <= lap_time;
        next_cp  <= 2'd1;
        if (final_lap) finished <= 1'b1;
      end else if (hit) begin
        next_cp <= next_cp + 2'd1;
      end

      // A lap completion clears the lap timer even on a tick edge.
      if (lap_done)                             lap_time <= 16'd0;
      else if (active && game_tick && lap_time != 16'hFFFF) lap_time <= lap_time + 16'd1;

      if (active && game_tick && race_time != 16'hFFFF) race_time <= race_time + 16'd1;
    end
  end

endmodule

// File: tb/tb_lap_tracker.sv
// tb_lap_tracker: directed bench for lap_tracker with CLK_FREQ=600 (tick every
// 11 clocks) and NUM_LAPS=2. Expected timer values come from counting tick
// edges inside the edge ranges where the car is actively racing.
module tb_lap_tracker;

  localparam int TICK_PERIOD = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  next_cp;
  logic [2:0]  lap_cnt;
  logic        lap_pulse;
  logic        finished;
  logic [15:0] lap_time, last_lap, best_lap, race_time;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  int pulse_cnt = 0;
  int tick0 = 0;

  lap_tracker #(.CLK_FREQ(600), .NUM_LAPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .next_cp   (next_cp),
    .lap_cnt   (lap_cnt),
    .lap_pulse (lap_pulse),
    .finished  (finished),
    .lap_time  (lap_time),
    .last_lap  (last_lap),
    .best_lap  (best_lap),
    .race_time (race_time)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  always @(posedge clk) edge_n <= edge_n + 1;

  // Count clocks during which the lap strobe is high.
  always @(negedge clk) if (lap_pulse) pulse_cnt <= pulse_cnt + 1;

  // Tick edges are tick0, tick0+11, ...; count those in [a,b].
  function automatic int count_ticks(input int a, input int b);
    int n = 0;
    for (int e = a; e <= b; e++)
      if (e >= tick0 && ((e - tick0) % TICK_PERIOD) == 0) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
    pos_x = x;
    pos_y = y;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_next_cp"},   16'(next_cp),   16'd1);
    check({tag, "_lap_cnt"},   16'(lap_cnt),   16'd0);
    check({tag, "_lap_pulse"}, 16'(lap_pulse), 16'd0);
    check({tag, "_finished"},  16'(finished),  16'd0);
    check({tag, "_lap_time"},  lap_time,       16'd0);
    check({tag, "_last_lap"},  last_lap,       16'd0);
    check({tag, "_best_lap"},  best_lap,       16'hFFFF);
    check({tag, "_race_time"}, race_time,      16'd0);
  endtask

  initial begin
    int start_act, seg1, resume_act, c1, c2, lap1, lap2, race1, race2, pulses_before;

    // Reset held for two clocks, car parked away from every gate.
    rst   = 1'b1;
    state = 3'd0;
    set_pos(10'd500, 10'd400);
    wait_cyc(2);
    check_reset_values("reset");
    rst   = 1'b0;
    tick0 = edge_n + 1;

    // Start racing; first edge moves IDLE->RACING, timing starts the edge after.
    state     = 3'd4;
    start_act = edge_n + 2;

    // Wrong order: gate 2 while gate 1 is expected.
    set_pos(10'd300, 10'd120);
    wait_cyc(5);
    check("wrong_order_next_cp", 16'(next_cp),   16'd1);
    check("wrong_order_pulse",   16'(pulse_cnt), 16'd0);

    // Ordered gates 1, 2, 3.
    set_pos(10'd160, 10'd20);
    wait_cyc(1);
    check("gate1_next_cp", 16'(next_cp), 16'd2);
    wait_cyc(20);
    set_pos(10'd300, 10'd120);
    wait_cyc(1);
    check("gate2_next_cp", 16'(next_cp), 16'd3);
    wait_cyc(20);
    set_pos(10'd160, 10'd220);
    wait_cyc(1);
    check("gate3_next_cp", 16'(next_cp), 16'd0);
    wait_cyc(20);

    // Pause for 50 ticks: timers must hold.
    state = 3'd2;
    seg1  = count_ticks(start_act, edge_n);
    wait_cyc(1);
    check("pause_lap_time",  lap_time,  16'(seg1));
    check("pause_race_time", race_time, 16'(seg1));
    wait_cyc(50 * TICK_PERIOD);
    check("paused_lap_time",  lap_time,  16'(seg1));
    check("paused_race_time", race_time, 16'(seg1));
    check("paused_next_cp",   16'(next_cp), 16'd0);

    // Resume and close lap 1 at gate 0.
    state      = 3'd4;
    resume_act = edge_n + 2;
    wait_cyc(30);
    set_pos(10'd0, 10'd120);
    c1    = edge_n + 1;
    lap1  = seg1 + count_ticks(resume_act, c1 - 1);
    race1 = seg1 + count_ticks(resume_act, c1);
    wait_cyc(1);
    check("lap1_pulse",     16'(lap_pulse), 16'd1);
    check("lap1_lap_cnt",   16'(lap_cnt),   16'd1);
    check("lap1_next_cp",   16'(next_cp),   16'd1);
    check("lap1_last_lap",  last_lap,       16'(lap1));
    check("lap1_best_lap",  best_lap,       16'(lap1));
    check("lap1_lap_time",  lap_time,       16'd0);
    check("lap1_race_time", race_time,      16'(race1));
    check("lap1_finished",  16'(finished),  16'd0);
    wait_cyc(1);
    check("lap1_pulse_drop", 16'(lap_pulse), 16'd0);
    wait_cyc(3);
    check("lap1_pulse_width", 16'(pulse_cnt), 16'd1);

    // Lap 2, faster.
    set_pos(10'd160, 10'd20);
    wait_cyc(10);
    set_pos(10'd300, 10'd120);
    wait_cyc(10);
    set_pos(10'd160, 10'd220);
    wait_cyc(10);
    set_pos(10'd0, 10'd120);
    c2    = edge_n + 1;
    lap2  = count_ticks(c1 + 1, c2 - 1);
    race2 = race1 + count_ticks(c1 + 1, c2);
    wait_cyc(1);
    check("lap2_pulse",     16'(lap_pulse), 16'd1);
    check("lap2_finished",  16'(finished),  16'd1);
    check("lap2_lap_cnt",   16'(lap_cnt),   16'd2);
    check("lap2_last_lap",  last_lap,       16'(lap2));
    check("lap2_best_lap",  best_lap,       16'(lap2));
    check("lap2_lap_time",  lap_time,       16'd0);
    check("lap2_race_time", race_time,      16'(race2));

    // DONE: further gate hits and ticks change nothing.
    wait_cyc(2);
    pulses_before = pulse_cnt;
    set_pos(10'd160, 10'd20);
    wait_cyc(40);
    set_pos(10'd0, 10'd120);
    wait_cyc(40);
    check("done_next_cp",   16'(next_cp),   16'd1);
    check("done_lap_cnt",   16'(lap_cnt),   16'd2);
    check("done_lap_time",  lap_time,       16'd0);
    check("done_race_time", race_time,      16'(race2));
    check("done_best_lap",  best_lap,       16'(lap2));
    check("done_finished",  16'(finished),  16'd1);
    check("done_no_pulse",  16'(pulse_cnt), 16'(pulses_before));
    check("total_pulses",   16'(pulse_cnt), 16'd2);

    // New game from DONE.
    state = 3'd0;
    set_pos(10'd173, 10'd20);
    wait_cyc(1);
    check_reset_values("new_game");

    // Gate boundary: CP1_X+13 misses, CP1_X+12 hits.
    state = 3'd4;
    wait_cyc(5);
    check("boundary_miss_next_cp", 16'(next_cp), 16'd1);
    set_pos(10'd172, 10'd20);
    wait_cyc(1);
    check("boundary_hit_next_cp", 16'(next_cp), 16'd2);

    // Mid-race reset.
    wait_cyc(30);
    rst = 1'b1;
    wait_cyc(1);
    check_reset_values("mid_reset");
    rst = 1'b0;
    wait_cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
